// File: rtl/count_readout_tx.sv
// count_readout_tx: UART-style transmitter for 8-bit capture-register count words.
// Frame is start, 8 data bits LSB-first, optional even parity, then 1 or 2 stop bits.
module count_readout_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter bit PARITY_EN    = 1'b0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       enable,
    input  logic [7:0] Din,
    input  logic       load,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic          stop_cnt, stop_n;
    logic [7:0]    sh, sh_n;
    logic          tx_n, busy_n, done_n, wrap, last_stop;

    assign wrap      = cnt == LAST;
    assign last_stop = (STOP_BITS == 1) || stop_cnt;
    assign ready     = (state == IDLE) && enable;

    always_comb begin
        state_n = state;
        cnt_n   = (state == IDLE || wrap) ? '0 : cnt + 1'b1;
        idx_n   = idx;
        stop_n  = stop_cnt;
        sh_n    = sh;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
        case (state)
            IDLE: if (load && ready) begin
                state_n = START;
                sh_n    = Din;
                tx_n    = 1'b0;
                busy_n  = 1'b1;
                idx_n   = '0;
                stop_n  = 1'b0;
            end
            START: if (wrap) begin
                state_n = DATA;
                tx_n    = sh[0];
            end
            DATA: if (wrap) begin
                if (idx == 3'd7) begin
                    state_n = PARITY_EN ? PARITY : STOP;
                    tx_n    = PARITY_EN ? ^sh : 1'b1;
                end else begin
                    idx_n = idx + 3'd1;
                    tx_n  = sh[idx + 3'd1];
                end
            end
            PARITY: if (wrap) begin
                state_n = STOP;
                tx_n    = 1'b1;
            end
            STOP: if (wrap) begin
                // the edge ending the last stop bit frees the line for a back-to-back accept
                if (last_stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    stop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            stop_cnt <= 1'b0;
            sh       <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            stop_cnt <= stop_n;
            sh       <= sh_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end
endmodule

// File: tb/tb_count_readout_tx.sv
// tb_count_readout_tx: scoreboard bench for count_readout_tx in three framing configurations.
// Instance 0: no parity, 1 stop; instance 1: even parity, 1 stop; instance 2: no parity, 2 stops.
module tb_count_readout_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] Din = '0;
    logic [2:0] load = '0;
    logic [2:0] ready, tx, busy, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_acc, last_start, last_done;
    logic last_par;
    logic [7:0] q[$];

    count_readout_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(1)) u0 (
        .clk(clk), .clear_n(clear_n), .enable(enable), .Din(Din), .load(load[0]),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    count_readout_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .STOP_BITS(1)) u1 (
        .clk(clk), .clear_n(clear_n), .enable(enable), .Din(Din), .load(load[1]),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    count_readout_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .STOP_BITS(2)) u2 (
        .clk(clk), .clear_n(clear_n), .enable(enable), .Din(Din), .load(load[2]),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic send(input int u, input logic [7:0] b, input bit hold);
        @(negedge clk);
        Din     = b;
        load[u] = 1'b1;
        q.push_back(b);
        for (int i = 0; i < 200 && !ready[u]; i++) @(negedge clk);
        tests++;
        if (ready[u] !== 1'b1) begin
            fails++;
            $display("FAIL send_ready u%0d: ready=%b required 1", u, ready[u]);
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (!hold) load[u] = 1'b0;
    endtask

    task automatic rx(input int u);
        logic [7:0] d, exp;
        bit got;
        int nstop, npar;
        nstop = (u == 2) ? 2 : 1;
        npar  = (u == 1) ? 1 : 0;
        got   = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = (tx[u] == 1'b0);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL rx_start u%0d: tx stayed 1, required a start bit", u);
            return;
        end
        last_start = cyc;
        repeat (CPB / 2 - 1) @(negedge clk);
        tests++;
        if (tx[u] !== 1'b0) begin
            fails++;
            $display("FAIL rx_start_mid u%0d: tx=%b required 0", u, tx[u]);
        end
        for (int k = 0; k < 8; k++) begin
            repeat (CPB) @(negedge clk);
            d[k] = tx[u];
        end
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL rx_queue u%0d: got byte %h with nothing expected", u, d);
            return;
        end
        exp = q.pop_front();
        tests++;
        if (d !== exp) begin
            fails++;
            $display("FAIL rx_data u%0d: got %h required %h", u, d, exp);
        end
        if (npar == 1) begin
            repeat (CPB) @(negedge clk);
            last_par = tx[u];
            tests++;
            if (tx[u] !== ^exp) begin
                fails++;
                $display("FAIL rx_parity u%0d: got %b required %b", u, tx[u], ^exp);
            end
        end
        for (int s = 0; s < nstop; s++) begin
            repeat (CPB) @(negedge clk);
            tests++;
            if (tx[u] !== 1'b1) begin
                fails++;
                $display("FAIL rx_stop%0d u%0d: tx=%b required 1", s, u, tx[u]);
            end
        end
        got = 1'b0;
        for (int i = 0; i < 2 * CPB && !got; i++) begin
            @(negedge clk);
            got = (done[u] == 1'b1);
        end
        last_done = cyc;
        tests++;
        if (!got || (last_done - last_start) != (9 + npar + nstop) * CPB) begin
            fails++;
            $display("FAIL rx_len u%0d: done seen=%0d after %0d cycles, required %0d", u, got,
                     last_done - last_start, (9 + npar + nstop) * CPB);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (tx !== 3'b111 || busy !== 3'b000 || done !== 3'b000 || ready !== 3'b000) begin
            fails++;
            $display("FAIL reset: tx=%b busy=%b done=%b ready=%b required 111 000 000 000",
                     tx, busy, done, ready);
        end
        enable  = 1'b1;
        clear_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ready !== 3'b111) begin
            fails++;
            $display("FAIL reset_release_ready: ready=%b required 111", ready);
        end
    endtask

    task automatic test_single();
        send(0, 8'hA5, 1'b0);
        rx(0);
        tests++;
        if (last_start != last_acc) begin
            fails++;
            $display("FAIL single_start_lat: start at %0d required %0d", last_start, last_acc);
        end
        tests++;
        if (last_done - last_acc != 40) begin
            fails++;
            $display("FAIL single_done_lat: %0d cycles required 40", last_done - last_acc);
        end
        @(negedge clk);
        tests++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL single_after: done=%b busy=%b ready=%b required 0 0 1",
                     done[0], busy[0], ready[0]);
        end
    endtask

    task automatic test_parity();
        send(1, 8'h07, 1'b0);
        rx(1);
        tests++;
        if (last_par !== 1'b1) begin
            fails++;
            $display("FAIL parity_07: got %b required 1", last_par);
        end
        send(1, 8'h03, 1'b0);
        rx(1);
        tests++;
        if (last_par !== 1'b0) begin
            fails++;
            $display("FAIL parity_03: got %b required 0", last_par);
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        send(2, 8'h55, 1'b1);
        Din = 8'h0F;
        q.push_back(8'h0F);
        rx(2);
        d1 = last_done;
        fork
            rx(2);
            begin
                @(posedge clk);
                #1 load[2] = 1'b0;
            end
        join
        tests++;
        if (last_start != d1 + 1) begin
            fails++;
            $display("FAIL b2b_gap: start at %0d required %0d", last_start, d1 + 1);
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL b2b_queue: %0d bytes left required 0", q.size());
        end
    endtask

    task automatic test_gating();
        int lows;
        send(0, 8'h3C, 1'b0);
        fork
            rx(0);
            begin
                repeat (10) @(negedge clk);
                enable = 1'b0;
            end
        join
        Din     = 8'h99;
        load[0] = 1'b1;
        lows    = 0;
        @(negedge clk);
        tests++;
        if (ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL gate_ready: ready=%b required 0", ready[0]);
        end
        repeat (100) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) lows++;
        end
        tests++;
        if (lows != 0) begin
            fails++;
            $display("FAIL gate_hold: %0d active cycles required 0", lows);
        end
        load[0] = 1'b0;
        enable  = 1'b1;
    endtask

    task automatic test_abort();
        send(0, 8'h00, 1'b0);
        void'(q.pop_back());
        repeat (13) @(posedge clk);
        #2 clear_n = 1'b0;
        #1;
        tests++;
        if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            fails++;
            $display("FAIL abort_async: tx=%b busy=%b done=%b required 1 0 0",
                     tx[0], busy[0], done[0]);
        end
        @(negedge clk);
        clear_n = 1'b1;
        send(0, 8'hC3, 1'b0);
        rx(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_gating();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
